// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
// master = producers/observers, slave = the arbiter itself.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH_BIT = 4
);
    logic                     alu_valid;
    logic [31:0]              alu_value;
    logic [ROB_WIDTH_BIT-1:0] alu_dest;
    logic [31:0]              alu_pc;
    logic                     alu_ready;
    logic                     ld_valid;
    logic [31:0]              ld_value;
    logic [ROB_WIDTH_BIT-1:0] ld_dest;
    logic                     ld_ready;
    logic                     st_valid;
    logic [ROB_WIDTH_BIT-1:0] st_dest;
    logic                     st_ready;
    logic                     cdb_valid;
    logic [1:0]               cdb_src;
    logic [ROB_WIDTH_BIT-1:0] cdb_dest;
    logic [31:0]              cdb_value;
    logic [31:0]              cdb_pc;

    modport master (
        output alu_valid, alu_value, alu_dest, alu_pc,
        output ld_valid, ld_value, ld_dest,
        output st_valid, st_dest,
        input  alu_ready, ld_ready, st_ready,
        input  cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_pc
    );

    modport slave (
        input  alu_valid, alu_value, alu_dest, alu_pc,
        input  ld_valid, ld_value, ld_dest,
        input  st_valid, st_dest,
        output alu_ready, ld_ready, st_ready,
        output cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_pc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among ALU, load and store
// result producers, each buffered by its own small FIFO.
module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_all,
    cdb_arbiter_if.slave bus
);
    localparam int NS = 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [ROB_WIDTH_BIT-1:0] tag_t;

    logic [31:0]    val_q  [NS][FIFO_DEPTH];
    logic [31:0]    val_d  [NS][FIFO_DEPTH];
    tag_t           dest_q [NS][FIFO_DEPTH];
    tag_t           dest_d [NS][FIFO_DEPTH];
    logic [31:0]    pc_q   [NS][FIFO_DEPTH];
    logic [31:0]    pc_d   [NS][FIFO_DEPTH];
    logic [PW-1:0]  wp_q   [NS];
    logic [PW-1:0]  wp_d   [NS];
    logic [PW-1:0]  rp_q   [NS];
    logic [PW-1:0]  rp_d   [NS];
    logic [CW-1:0]  cnt_q  [NS];
    logic [CW-1:0]  cnt_d  [NS];
    logic [1:0]     rr_q, rr_d;

    logic           cdb_valid_q, cdb_valid_d;
    logic [1:0]     cdb_src_q, cdb_src_d;
    tag_t           cdb_dest_q, cdb_dest_d;
    logic [31:0]    cdb_value_q, cdb_value_d;
    logic [31:0]    cdb_pc_q, cdb_pc_d;

    logic [NS-1:0]  push_vld, ready, push, pop;
    logic [31:0]    in_val  [NS];
    tag_t           in_dest [NS];
    logic [31:0]    in_pc   [NS];
    logic           found;
    logic [1:0]     win, idx;
    logic [2:0]     sum;

    // Store entries carry no data; loads and stores carry no jump target.
    always_comb begin
        push_vld   = {bus.st_valid, bus.ld_valid, bus.alu_valid};
        in_val[0]  = bus.alu_value;
        in_val[1]  = bus.ld_value;
        in_val[2]  = '0;
        in_dest[0] = bus.alu_dest;
        in_dest[1] = bus.ld_dest;
        in_dest[2] = bus.st_dest;
        in_pc[0]   = bus.alu_pc;
        in_pc[1]   = '0;
        in_pc[2]   = '0;
        ready      = '0;
        for (int i = 0; i < NS; i++) begin
            ready[i] = rdy_in && !clear_all
                    && (cnt_q[i] != CW'(FIFO_DEPTH));
        end
    end

    assign bus.alu_ready = ready[0];
    assign bus.ld_ready  = ready[1];
    assign bus.st_ready  = ready[2];

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < NS; k++) begin
            sum = {1'b0, rr_q} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        val_d       = val_q;
        dest_d      = dest_q;
        pc_d        = pc_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_src_d   = cdb_src_q;
        cdb_dest_d  = cdb_dest_q;
        cdb_value_d = cdb_value_q;
        cdb_pc_d    = cdb_pc_q;
        push        = '0;
        pop         = '0;
        if (rdy_in) begin
            if (clear_all) begin
                for (int i = 0; i < NS; i++) begin
                    wp_d[i]  = '0;
                    rp_d[i]  = '0;
                    cnt_d[i] = '0;
                end
                rr_d        = '0;
                cdb_valid_d = 1'b0;
            end else begin
                cdb_valid_d = found;
                if (found) begin
                    pop[win]    = 1'b1;
                    rr_d        = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    cdb_src_d   = win;
                    cdb_dest_d  = dest_q[win][rp_q[win]];
                    cdb_value_d = val_q[win][rp_q[win]];
                    cdb_pc_d    = pc_q[win][rp_q[win]];
                end
                push = push_vld & ready;
                for (int i = 0; i < NS; i++) begin
                    if (push[i]) begin
                        val_d[i][wp_q[i]]  = in_val[i];
                        dest_d[i][wp_q[i]] = in_dest[i];
                        pc_d[i][wp_q[i]]   = in_pc[i];
                        wp_d[i]            = wp_q[i] + PW'(1);
                    end
                    if (pop[i]) begin
                        rp_d[i] = rp_q[i] + PW'(1);
                    end
                    cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NS; i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_dest_q  <= '0;
            cdb_value_q <= '0;
            cdb_pc_q    <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_value_q <= cdb_value_d;
            cdb_pc_q    <= cdb_pc_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk_in) begin
        val_q  <= val_d;
        dest_q <= dest_d;
        pc_q   <= pc_d;
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_dest  = cdb_dest_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_pc    = cdb_pc_q;
endmodule
